// File: rtl/aes_round_key_store.sv
// AES round-key buffer: stores the expanded schedule once, then streams it
// word by word to the add-round-key stage in encrypt or decrypt round order.
//
// Ports:
//   RKS_I_CLK, RKS_I_RSTN        clock, async active-low reset
//   RKS_I_CLR                    synchronous discard of the stored schedule
//   RKS_I_WR_VALID/WORD, RKS_O_WR_READY   expansion write handshake
//   RKS_I_START, RKS_I_DECRYPT   begin a stream; direction sampled at START
//   RKS_I_NEXT                   consumer took the current word
//   RKS_O_KEY_OUT/KEY_VALID/B0   key word, valid, and XOR bypass select
//   RKS_O_ROUND/WIDX/LAST        position of KEY_OUT, final-word flag
//   RKS_O_LOADED                 full schedule stored
module aes_round_key_store #(
    parameter int NR = 10
) (
    input  logic        RKS_I_CLK,
    input  logic        RKS_I_RSTN,
    input  logic        RKS_I_CLR,
    input  logic        RKS_I_WR_VALID,
    input  logic [31:0] RKS_I_WR_WORD,
    output logic        RKS_O_WR_READY,
    input  logic        RKS_I_START,
    input  logic        RKS_I_DECRYPT,
    input  logic        RKS_I_NEXT,
    output logic [31:0] RKS_O_KEY_OUT,
    output logic        RKS_O_KEY_VALID,
    output logic        RKS_O_B0,
    output logic [3:0]  RKS_O_ROUND,
    output logic [1:0]  RKS_O_WIDX,
    output logic        RKS_O_LAST,
    output logic        RKS_O_LOADED
);

    localparam int DEPTH = 4 * (NR + 1);
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOADING,
        READY,
        STREAM
    } state_t;

    state_t         state;
    logic [AW-1:0]  wptr;
    logic           dec;
    logic [31:0]    mem [DEPTH];

    logic           acc;
    logic           dir;
    logic [3:0]     n_round;
    logic [1:0]     n_widx;
    logic           n_last;
    logic [AW-1:0]  n_addr;

    assign acc = RKS_I_WR_VALID & RKS_O_WR_READY & ~RKS_I_CLR;

    // Position of the word to present next: the first word of a new
    // stream when in READY, otherwise the successor of the current word.
    always_comb begin
        dir     = dec;
        n_round = RKS_O_ROUND;
        n_widx  = RKS_O_WIDX + 2'd1;
        if (state == READY) begin
            dir     = RKS_I_DECRYPT;
            n_round = RKS_I_DECRYPT ? 4'(NR) : 4'd0;
            n_widx  = 2'd0;
        end else if (RKS_O_WIDX == 2'd3) begin
            n_round = dec ? RKS_O_ROUND - 4'd1 : RKS_O_ROUND + 4'd1;
        end
        n_last = (n_widx == 2'd3) &&
                 (n_round == (dir ? 4'd0 : 4'(NR)));
        n_addr = AW'({n_round, 2'b00}) + AW'(n_widx);
    end

    // Schedule storage carries no reset; LOADED qualifies its contents.
    always_ff @(posedge RKS_I_CLK) begin
        if (acc) begin
            mem[wptr] <= RKS_I_WR_WORD;
        end
    end

    always_ff @(posedge RKS_I_CLK or negedge RKS_I_RSTN) begin
        if (!RKS_I_RSTN) begin
            state           <= IDLE;
            wptr            <= '0;
            dec             <= 1'b0;
            RKS_O_WR_READY  <= 1'b1;
            RKS_O_KEY_OUT   <= 32'd0;
            RKS_O_KEY_VALID <= 1'b0;
            RKS_O_B0        <= 1'b1;
            RKS_O_ROUND     <= 4'd0;
            RKS_O_WIDX      <= 2'd0;
            RKS_O_LAST      <= 1'b0;
            RKS_O_LOADED    <= 1'b0;
        end else if (RKS_I_CLR) begin
            state           <= IDLE;
            wptr            <= '0;
            RKS_O_WR_READY  <= 1'b1;
            RKS_O_KEY_OUT   <= 32'd0;
            RKS_O_KEY_VALID <= 1'b0;
            RKS_O_B0        <= 1'b1;
            RKS_O_ROUND     <= 4'd0;
            RKS_O_WIDX      <= 2'd0;
            RKS_O_LAST      <= 1'b0;
            RKS_O_LOADED    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (acc) begin
                        wptr  <= AW'(1);
                        state <= LOADING;
                    end
                end
                LOADING: begin
                    if (acc) begin
                        if (wptr == AW'(DEPTH - 1)) begin
                            state          <= READY;
                            RKS_O_WR_READY <= 1'b0;
                            RKS_O_LOADED   <= 1'b1;
                        end else begin
                            wptr <= wptr + AW'(1);
                        end
                    end
                end
                READY: begin
                    if (RKS_I_START) begin
                        state           <= STREAM;
                        dec             <= RKS_I_DECRYPT;
                        RKS_O_KEY_VALID <= 1'b1;
                        RKS_O_B0        <= 1'b0;
                        RKS_O_KEY_OUT   <= mem[n_addr];
                        RKS_O_ROUND     <= n_round;
                        RKS_O_WIDX      <= n_widx;
                        RKS_O_LAST      <= n_last;
                    end
                end
                STREAM: begin
                    if (RKS_I_NEXT) begin
                        if (RKS_O_LAST) begin
                            state           <= READY;
                            RKS_O_KEY_VALID <= 1'b0;
                            RKS_O_B0        <= 1'b1;
                            RKS_O_LAST      <= 1'b0;
                        end else begin
                            RKS_O_KEY_OUT <= mem[n_addr];
                            RKS_O_ROUND   <= n_round;
                            RKS_O_WIDX    <= n_widx;
                            RKS_O_LAST    <= n_last;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_key_store.sv
// Randomized self-checking bench for aes_round_key_store against a
// schedule-order reference model.
module tb_aes_round_key_store;

    localparam int NR    = 10;
    localparam int DEPTH = 4 * (NR + 1);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        wr_valid;
    logic [31:0] wr_word;
    logic        wr_ready;
    logic        start;
    logic        decrypt;
    logic        next;
    logic [31:0] key_out;
    logic        key_valid;
    logic        b0;
    logic [3:0]  round;
    logic [1:0]  widx;
    logic        last;
    logic        loaded;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ref_mem [DEPTH];

    aes_round_key_store #(.NR(NR)) dut (
        .RKS_I_CLK       (clk),
        .RKS_I_RSTN      (rst_n),
        .RKS_I_CLR       (clr),
        .RKS_I_WR_VALID  (wr_valid),
        .RKS_I_WR_WORD   (wr_word),
        .RKS_O_WR_READY  (wr_ready),
        .RKS_I_START     (start),
        .RKS_I_DECRYPT   (decrypt),
        .RKS_I_NEXT      (next),
        .RKS_O_KEY_OUT   (key_out),
        .RKS_O_KEY_VALID (key_valid),
        .RKS_O_B0        (b0),
        .RKS_O_ROUND     (round),
        .RKS_O_WIDX      (widx),
        .RKS_O_LAST      (last),
        .RKS_O_LOADED    (loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input bit rnd, input int n);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_word  = rnd ? $urandom : (32'hA500_0000 | i);
            ref_mem[i] = wr_word;
            chk("ld_ready", wr_ready, 1);
            tick();
            if (i == DEPTH - 2) chk("ld_not_yet", loaded, 0);
        end
        wr_valid = 1'b0;
        if (n == DEPTH) begin
            chk("ld_loaded", loaded, 1);
            chk("ld_full_rdy", wr_ready, 0);
            wr_valid = 1'b1;
            wr_word  = 32'hDEAD_BEEF;
            tick();
            wr_valid = 1'b0;
            chk("ld_extra_rdy", wr_ready, 0);
        end
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic run_stream(input bit dec, input int stall_at,
                              input int stall_len, input bit rnd_stall,
                              input int stop_after);
        int a_q[$];
        int r_q[$];
        int c_q[$];
        int n;
        int r;
        for (int k = 0; k <= NR; k++) begin
            r = dec ? NR - k : k;
            for (int c = 0; c < 4; c++) begin
                a_q.push_back(4 * r + c);
                r_q.push_back(r);
                c_q.push_back(c);
            end
        end
        start   = 1'b1;
        decrypt = dec;
        tick();
        start   = 1'b0;
        decrypt = 1'($urandom);
        for (int k = 0; k < a_q.size(); k++) begin
            if (k == stop_after) begin
                do_clear();
                chk("clr_kv", key_valid, 0);
                chk("clr_b0", b0, 1);
                chk("clr_loaded", loaded, 0);
                chk("clr_wrrdy", wr_ready, 1);
                chk("clr_key", key_out, 0);
                chk("clr_round", round, 0);
                start = 1'b1;
                tick();
                start = 1'b0;
                chk("clr_start_ign", key_valid, 0);
                return;
            end
            chk("kv", key_valid, 1);
            chk("b0", b0, 0);
            chk("key", key_out, ref_mem[a_q[k]]);
            chk("round", round, r_q[k]);
            chk("widx", widx, c_q[k]);
            chk("last", last, k == a_q.size() - 1);
            n = (k == stall_at) ? stall_len
                : (rnd_stall ? $urandom_range(0, 2) : 0);
            repeat (n) begin
                next    = 1'b0;
                start   = 1'($urandom);
                decrypt = 1'($urandom);
                tick();
                chk("hold_key", key_out, ref_mem[a_q[k]]);
                chk("hold_round", round, r_q[k]);
                chk("hold_widx", widx, c_q[k]);
            end
            start = 1'b0;
            next  = 1'b1;
            tick();
            next  = 1'b0;
        end
        chk("end_kv", key_valid, 0);
        chk("end_b0", b0, 1);
        chk("end_last", last, 0);
        chk("end_wrrdy", wr_ready, 0);
        chk("end_loaded", loaded, 1);
    endtask

    initial begin
        rst_n    = 1'b0;
        clr      = 1'b0;
        wr_valid = 1'b0;
        wr_word  = 32'd0;
        start    = 1'b0;
        decrypt  = 1'b0;
        next     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_wrrdy", wr_ready, 1);
        chk("rst_b0", b0, 1);
        chk("rst_kv", key_valid, 0);
        chk("rst_loaded", loaded, 0);
        chk("rst_key", key_out, 0);
        chk("rst_round", round, 0);
        chk("rst_widx", widx, 0);
        chk("rst_last", last, 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("idle_start_kv", key_valid, 0);
        chk("idle_start_rdy", wr_ready, 1);

        load(1'b0, DEPTH);
        run_stream(1'b0, -1, 0, 1'b0, -1);
        run_stream(1'b1, 1, 3, 1'b0, -1);

        next = 1'b1;
        tick();
        next = 1'b0;
        chk("next_inval_kv", key_valid, 0);

        run_stream(1'b0, -1, 0, 1'b0, 5);

        load(1'b1, DEPTH);
        for (int i = 0; i < 4; i++) begin
            run_stream(1'($urandom), -1, 0, 1'b1, -1);
        end

        start = 1'b1;
        clr   = 1'b1;
        tick();
        start = 1'b0;
        clr   = 1'b0;
        chk("stclr_kv", key_valid, 0);
        chk("stclr_rdy", wr_ready, 1);
        chk("stclr_loaded", loaded, 0);
        tick();
        chk("stclr_kv2", key_valid, 0);

        load(1'b1, 10);
        rst_n = 1'b0;
        #1;
        chk("rstld_rdy", wr_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rstld_loaded", loaded, 0);

        load(1'b1, DEPTH);
        run_stream(1'b1, -1, 0, 1'b1, -1);
        start = 1'b1;
        tick();
        start = 1'b0;
        next  = 1'b1;
        tick();
        tick();
        next  = 1'b0;
        chk("mid_kv_pre", key_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_kv", key_valid, 0);
        chk("mid_rst_b0", b0, 1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_rst_loaded", loaded, 0);
        chk("mid_rst_rdy", wr_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
